vol_ctrl_bar: RTL and testbench
===============================

Name: vol_ctrl_bar

Overview:
- Owns the playback volume for the MP3 player.
- Turns up/down/mute key levels into a saturating attenuation index, with auto-repeat while a key is held.
- Drives a parametrised LED bar-graph.
- Delivers the stereo VS1003 volume word to the SCI writer over a req/ack handshake, merging changes that arrive while a transfer is pending.

Parameters:
- LEVELS, 16: number of volume steps; index range is 0..LEVELS-1, where 0 is loudest. Must be 2..256.
- STEP, 8'h10: attenuation added per index step. LEVELS-1 times STEP must be at most 8'hFE.
- RESET_IDX, 4: index loaded at reset.
- REPEAT_DELAY, 20'd500000: cycles a key must be held before auto-repeat starts.
- REPEAT_RATE, 20'd100000: cycles between auto-repeat steps.

Ports:
- CLK, input, 1: system clock.
- RST_N, input, 1: asynchronous, active-low reset.
- key_up, input, 1: volume-up key level. Already debounced and synchronised; 1 means pressed.
- key_down, input, 1: volume-down key level. Same conditioning as key_up.
- mute_tog, input, 1: single-cycle pulse that toggles mute.
- vol_ack, input, 1: single-cycle pulse from the SCI writer meaning vol_out has been consumed.
- vol_req, output, 1: a transfer of vol_out is pending.
- vol_out, output, 16: {left, right} attenuation word. Held stable while vol_req=1.
- led, output, LEVELS: bar graph. LEDs [LEVELS-1-idx .. 0] are lit; all LEDs are off when muted.
- muted, output, 1: current mute state.

Behaviour:
- Reset (RST_N low, asynchronous):
  - idx=RESET_IDX, muted=0, key FSM=IDLE.
  - led and vol_out take their values for RESET_IDX.
  - vol_req=0 and pending=1, so the first cycle after release raises vol_req. The codec always receives the initial value.
- Attenuation rules:
  - att = idx*STEP, 8-bit.
  - vol_cur = {att, att} when not muted; 16'hFFFF when muted.
  - led = (2^LEVELS - 1) >> idx when not muted; 0 when muted.
  - idx=0 lights all LEVELS LEDs; idx=LEVELS-1 lights exactly LED[0].
  - led and muted are registered and update one cycle after the idx/mute change.
- Key FSM (IDLE, DELAY, REPEAT, with a 20-bit counter):
  - IDLE: exactly one of key_up/key_down is 1 → step once this cycle, clear the counter, go to DELAY.
  - DELAY: that key still held and the counter reaches REPEAT_DELAY-1 → step, clear, go to REPEAT.
  - REPEAT: the counter reaches REPEAT_RATE-1 → step, clear.
  - Any state: the active key is released, or both keys are 1 → go to IDLE with no step.
  - Both keys pressed from IDLE → no step.
  - The key held on entry to DELAY is the one that keeps repeating.
- Step rules:
  - Up: idx-1, saturating at 0.
  - Down: idx+1, saturating at LEVELS-1.
  - A step while muted clears mute and leaves idx unchanged for that step.
  - A step at a limit does nothing, and does not set pending.
- Mute:
  - mute_tog toggles muted.
  - If mute_tog and a step occur in the same cycle, the step wins and mute_tog is ignored.
- Change detection: any cycle in which vol_cur differs from its previous value sets pending.
- Handshake FSM (H_IDLE, H_REQ):
  - H_IDLE with pending=1 → latch vol_out=vol_cur, clear pending, set vol_req=1, go to H_REQ.
  - H_REQ: hold vol_out and vol_req. Changes to vol_cur only set pending.
  - H_REQ with vol_ack=1 → vol_req=0, go to H_IDLE.
  - If pending is set, the next request starts the cycle after ack, so vol_req drops low for at least one cycle.
  - Only the newest value is sent; intermediate values are dropped.
  - vol_ack seen in H_IDLE is ignored.
- Reset mid-transfer: vol_req drops immediately and the post-reset request is re-issued as described under Reset.

Decomposition:
- Shared package vol_pkg:
  - VS1003 constants: VOL_MUTE=16'hFFFF and the SCI_VOL register address 4'hB.
  - State encodings for the key and handshake FSMs.
- Sub-module key_repeat:
  - Contains the key FSM and its counter.
  - Outputs step_up and step_down pulses.
  - Reused later for track-skip keys.

Test Plan (LEVELS=16, STEP=8'h10, RESET_IDX=4, REPEAT_DELAY=20, REPEAT_RATE=5):
1. Release reset, ack after 3 cycles → vol_req rises in the first cycle after release, vol_out=16'h4040, led=16'h0FFF; vol_req falls after the ack.
2. Pulse key_down for 2 cycles, then ack → one step, vol_out=16'h5050, led=16'h07FF. Hold key_up for 20+5*3 cycles → idx steps at key_up rise, at +20, +25, +30 (from 5 to 1); no step after release.
3. From idx 0, press key_up → no change and no vol_req. From idx 15, press key_down → stays at 15, vol_out=16'hF0F0, led=16'h0001.
4. Pulse mute_tog → vol_out=16'hFFFF, led=0, muted=1. Press key_down → muted=0, idx unchanged, led restored.
5. Hold off ack while stepping from 4 to 7; ack → after one low cycle a second request carries only 16'h7070.
6. Hold key_up and key_down together → no step. Assert RST_N low while vol_req is high → vol_req clears immediately and idx returns to 4.

Source files
------------

// File: rtl/vol_pkg.sv
// Shared constants and state encodings for the volume control block.
package vol_pkg;

    // VS1003 volume word that fully silences both channels
    localparam logic [15:0] VOL_MUTE = 16'hFFFF;
    // VS1003 SCI register address of the volume register
    localparam logic [3:0]  SCI_VOL  = 4'hB;

    typedef enum logic [1:0] {
        K_IDLE   = 2'd0,
        K_DELAY  = 2'd1,
        K_REPEAT = 2'd2
    } key_st_e;

    typedef enum logic {
        H_IDLE = 1'b0,
        H_REQ  = 1'b1
    } hs_st_e;

    // Stereo attenuation word for a given index; attenuation wraps to 8 bits
    function automatic logic [15:0] vol_word(input logic [7:0] idx, input logic [7:0] step);
        logic [7:0] att;
        att = idx * step;
        return {att, att};
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Key auto-repeat: one step on press, another after DELAY cycles, then one every RATE cycles.
import vol_pkg::*;

module key_repeat #(
    parameter logic [19:0] DELAY = 20'd500000,
    parameter logic [19:0] RATE  = 20'd100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_up,
    input  logic i_key_down,
    output logic o_step_up,
    output logic o_step_down
);

    key_st_e     r_state, w_state_nxt;
    logic [19:0] r_cnt, w_cnt_nxt;
    logic        r_dir_up, w_dir_up_nxt;
    logic        w_one, w_held, w_fire;

    // exactly one key down; the key latched on entry to DELAY still held alone
    assign w_one  = i_key_up ^ i_key_down;
    assign w_held = r_dir_up ? (i_key_up & ~i_key_down) : (i_key_down & ~i_key_up);
    assign w_fire = ((r_state == K_DELAY)  && (r_cnt == DELAY - 20'd1)) ||
                    ((r_state == K_REPEAT) && (r_cnt == RATE  - 20'd1));

    // state, counter and repeating-key register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= K_IDLE;
            r_cnt    <= '0;
            r_dir_up <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dir_up <= w_dir_up_nxt;
        end
    end

    // next-state: release or both keys drop back to IDLE without stepping
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dir_up_nxt = r_dir_up;
        case (r_state)
            K_IDLE: begin
                if (w_one) begin
                    w_state_nxt  = K_DELAY;
                    w_cnt_nxt    = '0;
                    w_dir_up_nxt = i_key_up;
                end
            end
            K_DELAY, K_REPEAT: begin
                if (!w_held) begin
                    w_state_nxt = K_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_fire) begin
                    w_state_nxt = K_REPEAT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 20'd1;
                end
            end
            default: w_state_nxt = K_IDLE;
        endcase
    end

    // step pulses, same cycle as the press or the counter expiry
    always_comb begin
        o_step_up   = 1'b0;
        o_step_down = 1'b0;
        case (r_state)
            K_IDLE: begin
                if (w_one) begin
                    o_step_up   = i_key_up;
                    o_step_down = i_key_down;
                end
            end
            K_DELAY, K_REPEAT: begin
                if (w_held && w_fire) begin
                    o_step_up   = r_dir_up;
                    o_step_down = ~r_dir_up;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vol_ctrl_bar.sv
// Playback volume: key-driven attenuation index, LED bar and req/ack delivery of the VS1003 word.
import vol_pkg::*;

module vol_ctrl_bar #(
    parameter int          LEVELS       = 16,
    parameter logic [7:0]  STEP         = 8'h10,
    parameter int          RESET_IDX    = 4,
    parameter logic [19:0] REPEAT_DELAY = 20'd500000,
    parameter logic [19:0] REPEAT_RATE  = 20'd100000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              key_up,
    input  logic              key_down,
    input  logic              mute_tog,
    input  logic              vol_ack,
    output logic              vol_req,
    output logic [15:0]       vol_out,
    output logic [LEVELS-1:0] led,
    output logic              muted
);

    localparam int                IDX_W   = $clog2(LEVELS);
    localparam logic [IDX_W-1:0]  IDX_RST = IDX_W'(RESET_IDX);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(LEVELS - 1);
    localparam logic [LEVELS-1:0] LED_ALL = {LEVELS{1'b1}};
    localparam logic [15:0]       VOL_RST = vol_word(8'(RESET_IDX), STEP);

    logic [IDX_W-1:0]  r_idx;
    logic              r_mute;
    logic [LEVELS-1:0] r_led;
    logic              r_muted;
    logic [15:0]       r_vol_prev, r_vol_out;
    logic              r_pending;
    hs_st_e            r_hs, w_hs_nxt;
    logic              w_step_up, w_step_down, w_change;
    logic [7:0]        w_idx8;
    logic [15:0]       w_vol_cur;

    key_repeat #(
        .DELAY (REPEAT_DELAY),
        .RATE  (REPEAT_RATE)
    ) u_keys (
        .i_clk       (CLK),
        .i_rst_n     (RST_N),
        .i_key_up    (key_up),
        .i_key_down  (key_down),
        .o_step_up   (w_step_up),
        .o_step_down (w_step_down)
    );

    assign w_idx8    = 8'(r_idx);
    assign w_vol_cur = r_mute ? VOL_MUTE : vol_word(w_idx8, STEP);
    assign w_change  = (w_vol_cur != r_vol_prev);
    assign led       = r_led;
    assign muted     = r_muted;
    assign vol_out   = r_vol_out;

    // index and mute; a step always unmutes first and beats a same-cycle mute toggle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_idx  <= IDX_RST;
            r_mute <= 1'b0;
        end else if (w_step_up || w_step_down) begin
            if (r_mute)
                r_mute <= 1'b0;
            else if (w_step_up && (r_idx != '0))
                r_idx <= r_idx - IDX_W'(1);
            else if (w_step_down && (r_idx != IDX_MAX))
                r_idx <= r_idx + IDX_W'(1);
        end else if (mute_tog) begin
            r_mute <= ~r_mute;
        end
    end

    // registered bar graph and mute flag, one cycle behind the index
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_led   <= LED_ALL >> RESET_IDX;
            r_muted <= 1'b0;
        end else begin
            r_led   <= r_mute ? '0 : (LED_ALL >> r_idx);
            r_muted <= r_mute;
        end
    end

    // handshake state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_hs <= H_IDLE;
        else        r_hs <= w_hs_nxt;
    end

    // handshake next state; ack while idle is ignored
    always_comb begin
        w_hs_nxt = r_hs;
        case (r_hs)
            H_IDLE:  if (r_pending) w_hs_nxt = H_REQ;
            H_REQ:   if (vol_ack)   w_hs_nxt = H_IDLE;
            default: w_hs_nxt = H_IDLE;
        endcase
    end

    // handshake output
    always_comb begin
        vol_req = (r_hs == H_REQ);
    end

    // change tracking and word latch; pending starts set so the codec gets the reset value
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vol_prev <= VOL_RST;
            r_vol_out  <= VOL_RST;
            r_pending  <= 1'b1;
        end else begin
            r_vol_prev <= w_vol_cur;
            if ((r_hs == H_IDLE) && r_pending) begin
                r_vol_out <= w_vol_cur;
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending | w_change;
            end
        end
    end

endmodule

// File: tb/tb_vol_ctrl_bar.sv
// Randomized + directed bench for vol_ctrl_bar against a hold-count / queue-free reference model.
module tb_vol_ctrl_bar;

    localparam int D = 20;
    localparam int R = 5;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        key_up = 1'b0, key_down = 1'b0, mute_tog = 1'b0, vol_ack = 1'b0;
    logic        vol_req;
    logic [15:0] vol_out;
    logic [15:0] led;
    logic        muted;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    int          m_idx;
    bit          m_mute;
    int          m_key;   // 0 none, 1 up, 2 down
    int          m_hold;  // cycles the active key has been held (0 = press cycle)
    logic [15:0] m_led, m_out, m_prev;
    bit          m_muted, m_req, m_pend;

    vol_ctrl_bar #(
        .LEVELS(16), .STEP(8'h10), .RESET_IDX(4),
        .REPEAT_DELAY(20'd20), .REPEAT_RATE(20'd5)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .key_up(key_up), .key_down(key_down),
        .mute_tog(mute_tog), .vol_ack(vol_ack), .vol_req(vol_req),
        .vol_out(vol_out), .led(led), .muted(muted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] word_of(input int idx, input bit mute);
        logic [7:0] att;
        att = 8'(idx * 16);
        return mute ? 16'hFFFF : {att, att};
    endfunction

    task automatic model_reset();
        m_idx = 4; m_mute = 0; m_key = 0; m_hold = 0;
        m_led = 16'h0FFF; m_muted = 0; m_req = 0; m_pend = 1;
        m_out = 16'h4040; m_prev = 16'h4040;
    endtask

    // one clock of behaviour, all from pre-edge values
    task automatic model_step(input bit up, input bit dn, input bit mt, input bit ack);
        bit su, sd, held;
        logic [15:0] cur;
        su = 0; sd = 0;
        if (m_key == 0) begin
            if (up ^ dn) begin
                m_key = up ? 1 : 2; m_hold = 0; su = up; sd = dn;
            end
        end else begin
            held = (m_key == 1) ? (up && !dn) : (dn && !up);
            if (!held) m_key = 0;
            else begin
                m_hold++;
                if (m_hold == D || (m_hold > D && (m_hold - D) % R == 0)) begin
                    su = (m_key == 1); sd = (m_key == 2);
                end
            end
        end
        cur = word_of(m_idx, m_mute);
        if (!m_req) begin
            if (m_pend) begin m_out = cur; m_pend = 0; m_req = 1; end
            else if (cur != m_prev) m_pend = 1;
        end else begin
            if (cur != m_prev) m_pend = 1;
            if (ack) m_req = 0;
        end
        m_prev  = cur;
        m_led   = m_mute ? 16'h0 : (16'hFFFF >> m_idx);
        m_muted = m_mute;
        if (su || sd) begin
            if (m_mute) m_mute = 0;
            else if (su && m_idx > 0) m_idx--;
            else if (sd && m_idx < 15) m_idx++;
        end else if (mt) m_mute = !m_mute;
    endtask

    // drive one cycle of inputs at a negedge, then compare at the following negedge
    task automatic cyc(input bit up, input bit dn, input bit mt, input bit ack);
        key_up = up; key_down = dn; mute_tog = mt; vol_ack = ack;
        model_step(up, dn, mt, ack);
        @(negedge CLK);
        chk("vol_req", 32'(vol_req), 32'(m_req));
        chk("vol_out", 32'(vol_out), 32'(m_out));
        chk("led",     32'(led),     32'(m_led));
        chk("muted",   32'(muted),   32'(m_muted));
    endtask

    // let pending transfers drain, acking every request
    task automatic settle();
        for (int i = 0; i < 60; i++) begin
            if (!m_req && !m_pend && i > 3) break;
            cyc(0, 0, 0, m_req);
        end
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        chk("rst_req",   32'(vol_req), 32'h0);
        chk("rst_out",   32'(vol_out), 32'h4040);
        chk("rst_led",   32'(led),     32'h0FFF);
        chk("rst_muted", 32'(muted),   32'h0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge CLK);
        release_reset();

        // 1: initial value delivered
        cyc(0, 0, 0, 0);
        chk("t1_req_up", 32'(vol_req), 32'h1);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
        chk("t1_req_fall", 32'(vol_req), 32'h0);

        // 2: single step down, then auto-repeat up from 5 to 1
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        settle();
        chk("t2_out5", 32'(vol_out), 32'h5050);
        chk("t2_led5", 32'(led), 32'h07FF);
        repeat (35) cyc(1, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0);
        settle();
        chk("t2_out1", 32'(vol_out), 32'h1010);
        chk("t2_led1", 32'(led), 32'h7FFF);

        // 3: saturation at both ends
        cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
        settle();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk("t3_noreq0", 32'(vol_req), 32'h0);
        end
        repeat (100) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        settle();
        chk("t3_out15", 32'(vol_out), 32'hF0F0);
        chk("t3_led15", 32'(led), 32'h0001);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk("t3_noreq15", 32'(vol_req), 32'h0);
        end

        // 4: mute, then unmute by a step
        cyc(0, 0, 1, 0);
        settle();
        chk("t4_mout", 32'(vol_out), 32'hFFFF);
        chk("t4_mled", 32'(led), 32'h0);
        chk("t4_muted", 32'(muted), 32'h1);
        cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
        settle();
        chk("t4_unmuted", 32'(muted), 32'h0);
        chk("t4_led", 32'(led), 32'h0001);
        chk("t4_out", 32'(vol_out), 32'hF0F0);

        // 5: back to 4, then merge 4->7 while ack is held off
        repeat (67) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        settle();
        chk("t5_out4", 32'(vol_out), 32'h4040);
        repeat (3) begin cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); end
        repeat (4) cyc(0, 0, 0, 0);
        chk("t5_first", 32'(vol_out), 32'h5050);
        cyc(0, 0, 0, 1);
        chk("t5_gap", 32'(vol_req), 32'h0);
        cyc(0, 0, 0, 0);
        chk("t5_rereq", 32'(vol_req), 32'h1);
        chk("t5_newest", 32'(vol_out), 32'h7070);
        settle();

        // 6: both keys, then reset mid-transfer
        repeat (30) cyc(1, 1, 0, 0);
        chk("t6_both", 32'(vol_out), 32'h7070);
        cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("t6_busy", 32'(vol_req), 32'h1);
        #2 RST_N = 1'b0;
        #1;
        chk("t6_req_clr", 32'(vol_req), 32'h0);
        chk("t6_out_rst", 32'(vol_out), 32'h4040);
        chk("t6_led_rst", 32'(led), 32'h0FFF);
        chk("t6_muted_rst", 32'(muted), 32'h0);
        key_up = 0; key_down = 0; mute_tog = 0; vol_ack = 0;
        repeat (2) @(negedge CLK);
        release_reset();
        cyc(0, 0, 0, 0);
        chk("t6_rereq", 32'(vol_req), 32'h1);

        // random phase: key levels toggle rarely so holds reach repeat
        begin
            bit up, dn;
            up = 0; dn = 0;
            for (int i = 0; i < 2000; i++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 3) up = !up;
                else if (r < 6) dn = !dn;
                cyc(up, dn, $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
